pattern_led_ctrl: RTL and testbench

//  Parametrised LED pattern controller for the board I/O path. Builds a thermometer

---
 rtl/pattern_led_ctrl.sv | 123 ++++++++++++
 tb/tb_pattern_led_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_led_ctrl.sv
// LED pattern controller: thermometer base from switches, debounced
// button presses latch a display mode, registered LED output.
module pattern_led_ctrl #(
  parameter int LED_W        = 4,
  parameter int SW_W         = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int STEP_DIV     = 8,
  parameter int SHIFT        = 2
) (
  input  logic             clk_125,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw,
  input  logic [3:0]       btn,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode
);

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int PW = $clog2(LED_W);

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(STEP_DIV - 1);
  localparam logic [PW-1:0] PH_MAX  = PW'(LED_W - 1);

  logic [3:0]    s1, s2;
  logic [3:0]    db, db_q;
  logic [3:0]    rise;
  logic [CW-1:0] cnt [4];

  logic [1:0]       pick;
  logic [DW-1:0]    div;
  logic [PW-1:0]    phase;
  logic [LED_W-1:0] base;
  logic [LED_W-1:0] rot;
  logic [LED_W-1:0] xf;
  int               fill;

  always_ff @(posedge clk_125) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_q <= db;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise = db & ~db_q;

  // Highest-numbered press wins when several land together.
  always_comb begin
    pick = mode;
    priority case (1'b1)
      rise[3]: pick = 2'd3;
      rise[2]: pick = 2'd2;
      rise[1]: pick = 2'd1;
      rise[0]: pick = 2'd0;
      default: pick = mode;
    endcase
  end

  always_ff @(posedge clk_125) begin
    if (rst) begin
      mode <= 2'd0;
    end else if (|rise) begin
      mode <= pick;
    end
  end

  always_ff @(posedge clk_125) begin
    if (rst) begin
      div   <= '0;
      phase <= '0;
    end else if (rise[2]) begin
      div   <= '0;
      phase <= '0;
    end else if (mode == 2'd2) begin
      if (div == DIV_MAX) begin
        div   <= '0;
        phase <= (phase == PH_MAX) ? '0 : phase + PW'(1);
      end else begin
        div <= div + DW'(1);
      end
    end
  end

  always_comb begin
    fill = (int'(sw) + 1 < LED_W) ? int'(sw) + 1 : LED_W;
    base = LED_W'(((LED_W+1)'(1) << fill) - (LED_W+1)'(1));
    rot  = LED_W'(({base, base} << phase) >> LED_W);
    xf   = base;
    unique case (mode)
      2'd0: xf = base;
      2'd1: xf = base >> SHIFT;
      2'd2: xf = rot;
      2'd3: xf = ~base;
    endcase
  end

  always_ff @(posedge clk_125) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= xf;
    end
  end

endmodule

// File: tb/tb_pattern_led_ctrl.sv
// Bench for pattern_led_ctrl: directed scenarios plus random button
// and switch traffic against a run-length reference model.
module tb_pattern_led_ctrl;

  localparam int LW = 4;
  localparam int SD = 2;
  localparam int SH = 2;
  localparam int DB = 4;

  logic       clk_125 = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sw = 2'd0;
  logic [3:0] btn = 4'd0;
  logic [3:0] led;
  logic [1:0] mode;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] m_p0, m_p1, m_acc, m_accq;
  int         m_run [4];
  logic [1:0] m_mode;
  int         m_t;
  logic [3:0] m_led;

  always #4 clk_125 = ~clk_125;

  pattern_led_ctrl #(
    .LED_W(LW), .SW_W(2), .DEBOUNCE_CYC(DB),
    .STEP_DIV(SD), .SHIFT(SH)
  ) dut (
    .clk_125(clk_125), .rst(rst), .sw(sw),
    .btn(btn), .led(led), .mode(mode)
  );

  function automatic logic [3:0] ref_led(input int s, input int md,
                                         input int t);
    int b, p;
    b = (1 << ((s + 1 < LW) ? s + 1 : LW)) - 1;
    p = (t / SD) % LW;
    case (md)
      0:       return 4'(b);
      1:       return 4'(b >> SH);
      2:       return 4'((b << p) | (b >> (LW - p)));
      default: return 4'(~b);
    endcase
  endfunction

  // Model state after the coming rising edge, from current inputs.
  task automatic model_step();
    logic [3:0] r;
    logic [1:0] nm;
    int         nt;
    logic [3:0] nl;
    if (rst) begin
      m_p0 = 0; m_p1 = 0; m_acc = 0; m_accq = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_mode = 0; m_t = 0; m_led = 0;
    end else begin
      nl = ref_led(int'(sw), int'(m_mode), m_t);
      r  = m_acc & ~m_accq;
      nm = r[3] ? 2'd3 : r[2] ? 2'd2 : r[1] ? 2'd1 :
           r[0] ? 2'd0 : m_mode;
      nt = r[2] ? 0 : (m_mode == 2'd2 ? m_t + 1 : m_t);
      m_accq = m_acc;
      for (int i = 0; i < 4; i++) begin
        if (m_p1[i] == m_acc[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_acc[i] = m_p1[i];
            m_run[i] = 0;
          end
        end
      end
      m_p1 = m_p0; m_p0 = btn;
      m_mode = nm; m_t = nt; m_led = nl;
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk_125);
  endtask

  task automatic test_reset();
    rst = 1; btn = 0; sw = 0;
    repeat (3) tick();
    n_cmp++;
    if (led !== 4'b0000) begin
      n_bad++; $display("FAIL reset_led got %b exp 0000", led);
    end
    n_cmp++;
    if (mode !== 2'd0) begin
      n_bad++; $display("FAIL reset_mode got %0d exp 0", mode);
    end
    rst = 0;
    tick();
    n_cmp++;
    if (led !== 4'b0001) begin
      n_bad++; $display("FAIL first_load got %b exp 0001", led);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] tbl [4];
    tbl = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    for (int s = 0; s < 4; s++) begin
      sw = 2'(s);
      tick();
      n_cmp++;
      if (led !== tbl[s]) begin
        n_bad++;
        $display("FAIL sweep sw=%0d got %b exp %b", s, led, tbl[s]);
      end
      n_cmp++;
      if (led !== m_led) begin
        n_bad++; $display("FAIL sweep_model got %b exp %b", led, m_led);
      end
    end
  endtask

  task automatic test_mode1();
    logic [1:0] em;
    logic [3:0] el;
    sw = 2'd3; btn = 4'b0010;
    for (int i = 1; i <= 10; i++) begin
      tick();
      em = (i >= 7) ? 2'd1 : 2'd0;
      el = (i >= 8) ? 4'b0011 : 4'b1111;
      n_cmp++;
      if (mode !== em) begin
        n_bad++; $display("FAIL m1_mode i=%0d got %0d exp %0d", i, mode, em);
      end
      n_cmp++;
      if (led !== el) begin
        n_bad++; $display("FAIL m1_led i=%0d got %b exp %b", i, led, el);
      end
    end
    btn = 0;
    repeat (3) begin
      tick();
      n_cmp++;
      if (led !== 4'b0011) begin
        n_bad++; $display("FAIL m1_hold got %b exp 0011", led);
      end
    end
    sw = 2'd1;
    tick();
    n_cmp++;
    if (led !== 4'b0000) begin
      n_bad++; $display("FAIL m1_sw got %b exp 0000", led);
    end
    repeat (8) begin
      tick();
      n_cmp++;
      if (led !== m_led || mode !== m_mode) begin
        n_bad++;
        $display("FAIL m1_tail got %b/%0d exp %b/%0d",
                 led, mode, m_led, m_mode);
      end
    end
  endtask

  task automatic test_glitch_mode3();
    btn = 4'b1000;
    repeat (3) tick();
    btn = 0;
    repeat (8) begin
      tick();
      n_cmp++;
      if (mode !== 2'd1 || led !== 4'b0000) begin
        n_bad++;
        $display("FAIL glitch got %b/%0d exp 0000/1", led, mode);
      end
    end
    btn = 4'b1101;
    repeat (10) begin
      tick();
      n_cmp++;
      if (led !== m_led || mode !== m_mode) begin
        n_bad++;
        $display("FAIL m3_model got %b/%0d exp %b/%0d",
                 led, mode, m_led, m_mode);
      end
    end
    n_cmp++;
    if (mode !== 2'd3) begin
      n_bad++; $display("FAIL m3_mode got %0d exp 3", mode);
    end
    sw = 2'd2;
    tick();
    n_cmp++;
    if (led !== 4'b1000) begin
      n_bad++; $display("FAIL m3_led got %b exp 1000", led);
    end
    btn = 0;
    repeat (8) tick();
  endtask

  task automatic test_rotate();
    logic [3:0] el;
    sw = 2'd0; btn = 4'b0100;
    for (int i = 1; i <= 17; i++) begin
      tick();
      n_cmp++;
      if (led !== m_led || mode !== m_mode) begin
        n_bad++;
        $display("FAIL rot_model i=%0d got %b/%0d exp %b/%0d",
                 i, led, mode, m_led, m_mode);
      end
      if (i >= 8) begin
        el = 4'(1 << (((i - 8) / 2) % 4));
        n_cmp++;
        if (led !== el) begin
          n_bad++; $display("FAIL rot_step i=%0d got %b exp %b", i, led, el);
        end
      end
    end
    btn = 0;
    repeat (9) tick();
    btn = 4'b0100;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_cmp++;
      if (led !== m_led) begin
        n_bad++;
        $display("FAIL repress_model i=%0d got %b exp %b", i, led, m_led);
      end
      if (i >= 8) begin
        el = (i == 10) ? 4'b0010 : 4'b0001;
        n_cmp++;
        if (led !== el) begin
          n_bad++;
          $display("FAIL repress i=%0d got %b exp %b", i, led, el);
        end
      end
    end
    btn = 0;
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    logic [1:0] em;
    logic [3:0] el;
    sw = 2'd0; btn = 4'b1000;
    repeat (2) tick();
    rst = 1;
    tick();
    n_cmp++;
    if (led !== 4'b0000 || mode !== 2'd0) begin
      n_bad++; $display("FAIL mid_rst got %b/%0d exp 0000/0", led, mode);
    end
    rst = 0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      em = (j >= 7) ? 2'd3 : 2'd0;
      el = (j >= 8) ? 4'b1110 : 4'b0001;
      n_cmp++;
      if (mode !== em || led !== el) begin
        n_bad++;
        $display("FAIL mid_after j=%0d got %b/%0d exp %b/%0d",
                 j, led, mode, el, em);
      end
    end
    btn = 0;
    repeat (8) tick();
  endtask

  task automatic test_held_reset();
    btn = 4'b0100;
    repeat (3) tick();
    rst = 1;
    repeat (2) tick();
    rst = 0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      n_cmp++;
      if (led !== m_led || mode !== m_mode) begin
        n_bad++;
        $display("FAIL held j=%0d got %b/%0d exp %b/%0d",
                 j, led, mode, m_led, m_mode);
      end
      if (j == 7) begin
        n_cmp++;
        if (mode !== 2'd2) begin
          n_bad++; $display("FAIL held_mode got %0d exp 2", mode);
        end
      end
    end
    btn = 0;
    repeat (12) begin
      tick();
      n_cmp++;
      if (led !== m_led || mode !== 2'd2) begin
        n_bad++;
        $display("FAIL held_rel got %b/%0d exp %b/2", led, mode, m_led);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (hold == 0) begin
        btn  = ($urandom_range(0, 1) == 1) ?
               4'(1 << $urandom_range(0, 3)) : 4'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 3) == 0) sw = 2'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick();
      n_cmp++;
      if (led !== m_led || mode !== m_mode) begin
        n_bad++;
        $display("FAIL rand c=%0d got %b/%0d exp %b/%0d",
                 c, led, mode, m_led, m_mode);
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_mode1();
    test_glitch_mode3();
    test_rotate();
    test_reset_mid();
    test_held_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
